mandel_scan_ctrl: RTL and testbench
===================================

// Module: mandel_scan_ctrl
// PURPOSE
//  Upstream sequencer for the mandelbrot iteration core. Sweeps a COLS x ROWS pixel grid, drives the core's
//  load interface (14-bit 2.12 value, x/y select, load enable), waits for escape or the iteration limit, then
//  presents {row, col, iter, escape} downstream on a valid/ready handshake. One pixel in flight at a time.
// PARAMETERS
//  COLS  32  pixels per row, 1..256
//  ROWS  24  rows per frame, 1..256
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active-high
//  start        in   1   one-cycle pulse; begins a frame when idle
//  x_start      in   14  signed 2.12, real part of pixel (0,0)
//  y_start      in   14  signed 2.12, imaginary part of pixel (0,0)
//  x_step       in   14  signed 2.12, per-column increment
//  y_step       in   14  signed 2.12, per-row increment
//  iter_limit   in   7   early cutoff, 0..127
//  core_value   out  14  value to core (core's value_in)
//  core_sel_x   out  1   1 = load x, 0 = load y
//  core_load    out  1   core load enable
//  core_iter    in   7   core iteration count
//  core_escape  in   1   core registered escape flag
//  px_valid     out  1   pixel result valid
//  px_ready     in   1   downstream accepts
//  px_col       out  8   column of result
//  px_row       out  8   row of result
//  px_iter      out  7   iteration count captured
//  px_escape    out  1   1 = escaped, 0 = hit limit
//  busy         out  1   frame in progress
//  frame_done   out  1   one-cycle pulse after last pixel accepted
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; col/row counters 0; cur_x/cur_y 0. Reset mid-frame aborts, no frame_done.
//  States: IDLE -> LOAD_X -> LOAD_Y -> RUN -> EMIT -> (LOAD_X | IDLE).
//  IDLE: start=1 latches x/y_start into cur_x/cur_y, col=row=0, busy=1 next cycle; start ignored when busy.
//  LOAD_X (1 cycle): core_load=1, core_sel_x=1, core_value=cur_x.
//  LOAD_Y (1 cycle): core_load=1, core_sel_x=0, core_value=cur_y.
//  RUN: core_load=0. Done when core_escape=1 OR core_iter>=iter_limit OR core_iter==127; on done, capture
//   px_iter=core_iter, px_escape=core_escape, px_col=col, px_row=row; px_valid=1 next cycle (EMIT).
//   First RUN cycle is checked (core shows iter=0, escape=0 after load); iter_limit=0 -> RUN lasts 1 cycle.
//  core_value/core_sel_x are 0 whenever core_load=0.
//  EMIT: px_valid and px_* held stable until px_ready=1. On accept: px_valid=0 next cycle;
//   if col<COLS-1: col+=1, cur_x+=x_step; else col=0, cur_x=x_start, row+=1, cur_y+=y_step.
//   Last pixel (col=COLS-1,row=ROWS-1) accepted -> IDLE, busy=0, frame_done=1 for one cycle.
//  Arithmetic: cur_x/cur_y 14-bit two's complement, wrap modulo 2^14, no saturation.
//  x/y_start and steps sampled at start and on each row/column advance; callers hold them stable for a frame.
//  Latency: start@T -> LOAD_X@T+1, LOAD_Y@T+2, RUN@T+3; earliest px_valid@T+4 (iter_limit=0).
//  px_ready during non-EMIT states has no effect. start and accept in same cycle: start ignored.
// TESTING
//  COLS=2,ROWS=2, x_start=y_start=0x3000 (-1.0... set -1.0 as 0x3000), steps 0x0400, limit 127, px_ready=1 ->
//   4 pixels in order (0,0),(1,0),(0,1),(1,1), core_value seq x=0x3000,0x3400; frame_done once.
//  Core model escapes at iter 5 -> px_iter=5, px_escape=1; limit 10 with no escape -> px_iter=10, px_escape=0.
//  iter_limit=0 -> every pixel px_iter=0, px_valid@T+4 after start@T.
//  Hold px_ready=0 20 cycles in EMIT -> px_* stable, no new core_load; release -> advances exactly one pixel.
//  x_start=0x1FFF, x_step=0x0001, COLS=2 -> second column core_value=0x2000 (wrap).
//  rst asserted in RUN -> next cycle all outputs 0, IDLE; start while busy -> no effect on sequence.

Source files
------------

// File: rtl/mandel_scan_ctrl.sv
// rtl/mandel_scan_ctrl.sv - pixel-grid sequencer feeding the mandelbrot iteration core
module mandel_scan_ctrl #(
  parameter int COLS = 32,
  parameter int ROWS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] x_start,
  input  logic [13:0] y_start,
  input  logic [13:0] x_step,
  input  logic [13:0] y_step,
  input  logic [6:0]  iter_limit,
  output logic [13:0] core_value,
  output logic        core_sel_x,
  output logic        core_load,
  input  logic [6:0]  core_iter,
  input  logic        core_escape,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [7:0]  px_col,
  output logic [7:0]  px_row,
  output logic [6:0]  px_iter,
  output logic        px_escape,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    LOAD_Y = 3'd2,
    RUN    = 3'd3,
    EMIT   = 3'd4
  } state_t;

  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

  state_t      state_q, state_d;
  logic [7:0]  col_q, col_d;
  logic [7:0]  row_q, row_d;
  logic [13:0] cur_x_q, cur_x_d;
  logic [13:0] cur_y_q, cur_y_d;
  logic [7:0]  px_col_q, px_col_d;
  logic [7:0]  px_row_q, px_row_d;
  logic [6:0]  px_iter_q, px_iter_d;
  logic        px_escape_q, px_escape_d;
  logic        frame_done_q, frame_done_d;
  logic        run_done;

  // A pixel finishes on escape, on the caller's limit, or when the core's counter saturates.
  assign run_done = core_escape || (core_iter >= iter_limit) || (core_iter == 7'd127);

  // State and datapath registers; reset aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      px_col_q     <= '0;
      px_row_q     <= '0;
      px_iter_q    <= '0;
      px_escape_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      px_col_q     <= px_col_d;
      px_row_q     <= px_row_d;
      px_iter_q    <= px_iter_d;
      px_escape_q  <= px_escape_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state, grid advance and core load interface.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    px_col_d     = px_col_q;
    px_row_d     = px_row_q;
    px_iter_d    = px_iter_q;
    px_escape_d  = px_escape_q;
    frame_done_d = 1'b0;
    core_load    = 1'b0;
    core_sel_x   = 1'b0;
    core_value   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_x_d = x_start;
          cur_y_d = y_start;
          col_d   = '0;
          row_d   = '0;
          state_d = LOAD_X;
        end
      end
      LOAD_X: begin
        core_load  = 1'b1;
        core_sel_x = 1'b1;
        core_value = cur_x_q;
        state_d    = LOAD_Y;
      end
      LOAD_Y: begin
        core_load  = 1'b1;
        core_value = cur_y_q;
        state_d    = RUN;
      end
      RUN: begin
        if (run_done) begin
          px_iter_d   = core_iter;
          px_escape_d = core_escape;
          px_col_d    = col_q;
          px_row_d    = row_q;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (px_ready) begin
          if (col_q == LAST_COL) begin
            col_d   = '0;
            cur_x_d = x_start;
            if (row_q == LAST_ROW) begin
              state_d      = IDLE;
              frame_done_d = 1'b1;
            end else begin
              row_d   = row_q + 8'd1;
              cur_y_d = cur_y_q + y_step;
              state_d = LOAD_X;
            end
          end else begin
            col_d   = col_q + 8'd1;
            cur_x_d = cur_x_q + x_step;
            state_d = LOAD_X;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign px_valid   = (state_q == EMIT);
  assign busy       = (state_q != IDLE);
  assign px_col     = px_col_q;
  assign px_row     = px_row_q;
  assign px_iter    = px_iter_q;
  assign px_escape  = px_escape_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mandel_scan_ctrl.sv
// tb/tb_mandel_scan_ctrl.sv - self-checking bench for mandel_scan_ctrl on a 2x2 grid
module tb_mandel_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, px_ready;
  logic [13:0] x_start, y_start, x_step, y_step;
  logic [6:0]  iter_limit;
  logic [13:0] core_value;
  logic        core_sel_x, core_load;
  logic [6:0]  core_iter;
  logic        core_escape;
  logic        px_valid;
  logic [7:0]  px_col, px_row;
  logic [6:0]  px_iter;
  logic        px_escape, busy, frame_done;

  always #5 clk = ~clk;

  mandel_scan_ctrl #(.COLS(2), .ROWS(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_start(x_start), .y_start(y_start), .x_step(x_step), .y_step(y_step),
    .iter_limit(iter_limit),
    .core_value(core_value), .core_sel_x(core_sel_x), .core_load(core_load),
    .core_iter(core_iter), .core_escape(core_escape),
    .px_valid(px_valid), .px_ready(px_ready),
    .px_col(px_col), .px_row(px_row), .px_iter(px_iter), .px_escape(px_escape),
    .busy(busy), .frame_done(frame_done)
  );

  // Core model: a load clears it; it then counts once per cycle until escape or 127.
  logic       esc_en;
  logic [6:0] esc_at;
  always @(posedge clk) begin
    if (rst || core_load) begin
      core_iter   <= 7'd0;
      core_escape <= 1'b0;
    end else if (!core_escape && core_iter != 7'd127) begin
      core_iter   <= core_iter + 7'd1;
      core_escape <= esc_en && ((core_iter + 7'd1) == esc_at);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [13:0] xs, ys, xst, yst;
    logic [6:0]  lim;
    logic        en;
    logic [6:0]  at;
    logic [6:0]  exp_iter;
    logic        exp_esc;
    logic        spam;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic run_frame(input vec_t v, input int idx);
    logic [13:0] lx[4];
    logic [13:0] ly[4];
    logic [13:0] ex, ey;
    int nx, ny, n, fd, lat, cyc, bad;
    for (int i = 0; i < 4; i++) begin
      lx[i] = 'x;
      ly[i] = 'x;
    end
    nx = 0; ny = 0; n = 0; fd = 0; lat = -1; cyc = 1; bad = 0;
    x_start = v.xs; y_start = v.ys; x_step = v.xst; y_step = v.yst;
    iter_limit = v.lim; esc_en = v.en; esc_at = v.at;
    px_ready = 1'b1;
    start = 1'b1;
    step();
    while (fd == 0 && cyc < 3000) begin
      if (core_load) begin
        if (core_sel_x && nx < 4) begin lx[nx] = core_value; nx++; end
        if (!core_sel_x && ny < 4) begin ly[ny] = core_value; ny++; end
      end else if (core_value != 14'd0 || core_sel_x) begin
        bad++;
      end
      if (px_valid) begin
        if (lat < 0) lat = cyc;
        if (n < 4) begin
          chk($sformatf("v%0d px_col[%0d]", idx, n), px_col, n % 2);
          chk($sformatf("v%0d px_row[%0d]", idx, n), px_row, n / 2);
          chk($sformatf("v%0d px_iter[%0d]", idx, n), px_iter, v.exp_iter);
          chk($sformatf("v%0d px_escape[%0d]", idx, n), px_escape, v.exp_esc);
        end
        n++;
      end
      if (frame_done) fd++;
      start = v.spam && busy && (n < 3);
      if (fd == 0) begin
        step();
        cyc++;
      end
    end
    start = 1'b0;
    chk($sformatf("v%0d pixel_count", idx), n, 4);
    chk($sformatf("v%0d frame_done_seen", idx), fd, 1);
    chk($sformatf("v%0d busy_at_done", idx), busy, 0);
    chk($sformatf("v%0d first_valid_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d idle_core_value", idx), bad, 0);
    for (int i = 0; i < 4; i++) begin
      ex = v.xs + (((i % 2) == 1) ? v.xst : 14'd0);
      ey = v.ys + (((i / 2) == 1) ? v.yst : 14'd0);
      chk($sformatf("v%0d load_x[%0d]", idx, i), lx[i], ex);
      chk($sformatf("v%0d load_y[%0d]", idx, i), ly[i], ey);
    end
    step();
    chk($sformatf("v%0d frame_done_pulse", idx), frame_done, 0);
    chk($sformatf("v%0d no_restart", idx), busy, 0);
  endtask

  logic [7:0]  h_col, h_row;
  logic [6:0]  h_iter;
  logic        h_esc;
  int          hold_bad, w;

  initial begin
    //        xs        ys        xst       yst       lim  en  at   iter esc spam lat
    vecs[0] = '{14'h3000, 14'h3000, 14'h0400, 14'h0400, 7'd127, 1'b1, 7'd5, 7'd5,   1'b1, 1'b0, 9};
    vecs[1] = '{14'h3000, 14'h3000, 14'h0400, 14'h0400, 7'd10,  1'b0, 7'd0, 7'd10,  1'b0, 1'b0, 14};
    vecs[2] = '{14'h0100, 14'h0200, 14'h0010, 14'h0020, 7'd0,   1'b0, 7'd0, 7'd0,   1'b0, 1'b1, 4};
    vecs[3] = '{14'h1FFF, 14'h0000, 14'h0001, 14'h3FFF, 7'd127, 1'b0, 7'd0, 7'd127, 1'b0, 1'b0, 131};
    vecs[4] = '{14'h2000, 14'h1000, 14'h0800, 14'h0001, 7'd3,   1'b1, 7'd3, 7'd3,   1'b1, 1'b1, 7};

    rst = 1'b1; start = 1'b0; px_ready = 1'b0;
    x_start = '0; y_start = '0; x_step = '0; y_step = '0;
    iter_limit = '0; esc_en = 1'b0; esc_at = '0;
    step(); step(); step();
    chk("reset busy", busy, 0);
    chk("reset px_valid", px_valid, 0);
    chk("reset core_load", core_load, 0);
    chk("reset core_value", core_value, 0);
    chk("reset px_fields", {px_col, px_row, px_iter, px_escape}, 0);
    chk("reset frame_done", frame_done, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

    // Backpressure: the pixel must hold and the core must stay idle while ready is low.
    x_start = 14'h0000; y_start = 14'h0000; x_step = 14'h0004; y_step = 14'h0008;
    iter_limit = 7'd0; esc_en = 1'b0; px_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    w = 0;
    while (!px_valid && w < 50) begin step(); w++; end
    chk("hold first_valid", px_valid, 1);
    h_col = px_col; h_row = px_row; h_iter = px_iter; h_esc = px_escape;
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!px_valid || core_load || px_col != h_col || px_row != h_row ||
          px_iter != h_iter || px_escape != h_esc) hold_bad++;
    end
    chk("hold stable", hold_bad, 0);
    chk("hold col", h_col, 0);
    px_ready = 1'b1; step(); px_ready = 1'b0;
    chk("hold accept_drops_valid", px_valid, 0);
    chk("hold accept_loads_x", {core_load, core_sel_x, core_value}, {1'b1, 1'b1, 14'h0004});
    w = 0;
    while (!px_valid && w < 50) begin step(); w++; end
    chk("hold second_col", px_col, 1);
    chk("hold second_row", px_row, 0);
    step(); step();
    chk("hold one_pixel_only", {px_valid, px_col}, {1'b1, 8'd1});

    // Reset while the core is running aborts the frame with no done pulse.
    rst = 1'b1; step(); rst = 1'b0;
    iter_limit = 7'd127; esc_en = 1'b0; px_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("run state entered", {busy, core_load}, {1'b1, 1'b0});
    rst = 1'b1; step();
    chk("rst_run outputs", {core_value, core_sel_x, core_load, px_valid, px_col, px_row,
                            px_iter, px_escape, busy, frame_done}, 0);
    rst = 1'b0;
    hold_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busy || frame_done || core_load) hold_bad++;
    end
    chk("rst_run stays idle", hold_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
